shoe_counter: RTL and testbench
===============================

Name: shoe_counter

Overview:
- Parametrised successor to the single-shoe Hi-Lo counter.
- Tracks the loaded deck count and per-category card totals (small 2-6, seven 7-9, large 10-A).
- Derives the running count and remaining cards.
- Adds multi-step undo through a bounded history ring, explicit rejection of illegal events, and an optional sequential true-count divider.

Parameters:
- DECK_W, 8, width of deck count.
- MAX_DECKS, 8, deck_add is rejected once deck equals this value.
- TOTAL_W, 16, width of all card totals; offset is signed TOTAL_W.
- HIST_DEPTH, 16, number of undoable card events (power of 2, at least 2).
- SMALL_PER_DECK, 20, small cards per deck.
- SEVEN_PER_DECK, 12, seven-class cards per deck.
- LARGE_PER_DECK, 20, large cards per deck.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- small_add  input  1  one-cycle pulse: small card dealt
- seven_add  input  1  one-cycle pulse: 7-9 dealt
- large_add  input  1  one-cycle pulse: large card dealt
- deck_add  input  1  one-cycle pulse: load one more deck
- back  input  1  one-cycle pulse: undo last accepted card
- deck  output  DECK_W  decks loaded
- small_total, seven_total, large_total  output  TOTAL_W each  per-category counts
- total  output  TOTAL_W  sum of the three category counts
- remaining  output  TOTAL_W  52*deck - total
- offset  output  TOTAL_W signed  running count = small_total - large_total
- hist_cnt  output  $clog2(HIST_DEPTH)+1  undoable entries held
- err  output  1  one-cycle pulse: event in the previous cycle was rejected

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs become 0, the history ring is cleared, and err is 0. Reset mid-operation discards everything, including the ring.
- Latency: every accepted event updates the registered outputs on the next clk edge. err asserts on the same edge as the rejected event's would-be update and lasts one cycle.
- Event priority within a cycle: rst, then back, then deck_add, then card adds. Lower-priority events in the same cycle are ignored. Ignoring them does not raise err unless two or more card adds arrive together with no higher event.
- Card add:
  - Exactly one of small_add, seven_add, large_add must be high.
  - The event is rejected (err) if the category count already equals deck * its PER_DECK limit. With deck=0, every card add is rejected.
  - On accept: category +1, total +1, remaining -1, offset +1 (small) / 0 (seven) / -1 (large).
  - The category code (small=0, seven=1, large=2) is pushed into the ring.
- History ring:
  - Circular buffer with a write pointer; hist_cnt saturates at HIST_DEPTH.
  - A push when full overwrites the oldest entry, which makes that entry un-undoable.
- back:
  - If hist_cnt is 0, the event is rejected (err) and there is no state change.
  - Otherwise pop the newest entry and reverse its effect exactly: category -1, total -1, offset reversed.
  - The write pointer decrements modulo HIST_DEPTH.
- deck_add:
  - Accepted only when total is 0 and deck is below MAX_DECKS; otherwise err.
  - On accept: deck +1, remaining +52. Not recorded in the history ring.
- Invariants (checked by the bind checker):
  - total equals the sum of the three category counts.
  - Each category count is at most deck times its per-deck limit.
  - offset is within plus or minus deck*max(SMALL_PER_DECK, LARGE_PER_DECK).
  - deck is stable while total > 0.
- Arithmetic:
  - All sums are computed at TOTAL_W.
  - 52*deck is computed at TOTAL_W. MAX_DECKS*52 must fit in TOTAL_W, which is an elaboration-time check.

Optional Feature:
- Macro: SHOE_COUNTER_TRUE_COUNT_EN.
- Ports added when defined: true_count (output, TOTAL_W signed) and tc_valid (output, 1).
- Computation:
  - true_count = trunc_toward_zero(offset*52 / remaining).
  - Uses a sequential restoring divider on the magnitude, one quotient bit per cycle, TOTAL_W+6 iterations, with the sign applied at the end.
- Restart and valid timing:
  - Any accepted event restarts the divider and drops tc_valid on the next edge.
  - tc_valid rises TOTAL_W+7 cycles after the last accepted event.
- If remaining is 0, true_count is 0 and tc_valid is 1 after one cycle.
- Reset values: true_count=0, tc_valid=1.
- When the macro is undefined, these ports and all divider logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then deck_add x2, then small_add x3 and large_add x1 -> deck=2, total=4, remaining=100, offset=+2, err never asserted.
- deck=1, then 20 small_add followed by a 21st small_add -> small_total=20, err pulses once on the 21st, offset=+20 held.
- After 5 cards, back x5 then one more back -> totals return to 0, offset=0, hist_cnt=0, err on the 6th back only.
- HIST_DEPTH=16, 18 seven_add with deck=2, then back x17 -> the 17th back errs, seven_total=2.
- With total=1, deck_add -> err, deck unchanged. Small_add and large_add in the same cycle -> err, no change. Back with deck_add in the same cycle -> only the undo occurs.
- TRUE_COUNT_EN, deck=1, 6 small_add -> after TOTAL_W+7 quiet cycles, tc_valid=1 and true_count=6*52/46=6. Adding one large mid-divide drops tc_valid, and the result becomes 5*52/45=5.

Source files
------------

// File: rtl/shoe_counter.sv
// Hi-Lo shoe counter with per-category totals, bounded multi-step undo and rejected-event flag.
// Optional true-count divider enabled by defining SHOE_COUNTER_TRUE_COUNT_EN.
module shoe_counter #(
   parameter int DECK_W         = 8,
   parameter int MAX_DECKS      = 8,
   parameter int TOTAL_W        = 16,
   parameter int HIST_DEPTH     = 16,
   parameter int SMALL_PER_DECK = 20,
   parameter int SEVEN_PER_DECK = 12,
   parameter int LARGE_PER_DECK = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         small_add,
   input  logic                         seven_add,
   input  logic                         large_add,
   input  logic                         deck_add,
   input  logic                         back,
   output logic [DECK_W-1:0]            deck,
   output logic [TOTAL_W-1:0]           small_total,
   output logic [TOTAL_W-1:0]           seven_total,
   output logic [TOTAL_W-1:0]           large_total,
   output logic [TOTAL_W-1:0]           total,
   output logic [TOTAL_W-1:0]           remaining,
   output logic signed [TOTAL_W-1:0]    offset,
   output logic [$clog2(HIST_DEPTH):0]  hist_cnt,
   output logic                         err
`ifdef SHOE_COUNTER_TRUE_COUNT_EN
   ,
   output logic signed [TOTAL_W-1:0]    true_count,
   output logic                         tc_valid
`endif
);

   localparam int PTR_W = $clog2(HIST_DEPTH);
   localparam int HC_W  = PTR_W + 1;
   localparam logic [TOTAL_W-1:0] ONE_T = TOTAL_W'(1);

   typedef enum logic [1:0] {
      CAT_SMALL = 2'd0,
      CAT_SEVEN = 2'd1,
      CAT_LARGE = 2'd2
   } cat_e;

   if (MAX_DECKS * 52 > (2 ** TOTAL_W) - 1) begin : g_total_w_check
      $error("shoe_counter: MAX_DECKS*52 does not fit in TOTAL_W");
   end
   if (HIST_DEPTH < 2 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_hist_check
      $error("shoe_counter: HIST_DEPTH must be a power of 2, at least 2");
   end

   function automatic logic [TOTAL_W-1:0] per_deck(input logic [DECK_W-1:0] d, input int per);
      return TOTAL_W'(d) * TOTAL_W'(per);
   endfunction

   logic [1:0]       hist_mem [HIST_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] pop_ptr;
   cat_e             pop_cat;

   logic [1:0]         n_cards;
   cat_e               add_cat;
   logic [TOTAL_W-1:0] add_cnt;
   logic [TOTAL_W-1:0] add_lim;
   logic               do_pop, do_deck, do_push, reject;

   assign total     = small_total + seven_total + large_total;
   assign remaining = per_deck(deck, 52) - total;
   assign offset    = $signed(small_total) - $signed(large_total);
   assign pop_ptr   = wr_ptr - PTR_W'(1);
   assign pop_cat   = cat_e'(hist_mem[pop_ptr]);
   assign n_cards   = {1'b0, small_add} + {1'b0, seven_add} + {1'b0, large_add};

   // Event arbitration: back beats deck_add beats card adds.
   always_comb begin
      do_pop  = 1'b0;
      do_deck = 1'b0;
      do_push = 1'b0;
      reject  = 1'b0;
      add_cat = CAT_SMALL;
      add_cnt = small_total;
      add_lim = per_deck(deck, SMALL_PER_DECK);
      if (seven_add) begin
         add_cat = CAT_SEVEN;
         add_cnt = seven_total;
         add_lim = per_deck(deck, SEVEN_PER_DECK);
      end else if (large_add) begin
         add_cat = CAT_LARGE;
         add_cnt = large_total;
         add_lim = per_deck(deck, LARGE_PER_DECK);
      end
      if (back) begin
         if (hist_cnt == '0) reject = 1'b1;
         else                do_pop = 1'b1;
      end else if (deck_add) begin
         if (total == '0 && deck < DECK_W'(MAX_DECKS)) do_deck = 1'b1;
         else                                          reject  = 1'b1;
      end else if (n_cards > 2'd1) begin
         reject = 1'b1;
      end else if (n_cards == 2'd1) begin
         if (add_cnt >= add_lim) reject  = 1'b1;
         else                    do_push = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deck        <= '0;
         small_total <= '0;
         seven_total <= '0;
         large_total <= '0;
         wr_ptr      <= '0;
         hist_cnt    <= '0;
         err         <= 1'b0;
         for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= 2'd0;
      end else begin
         err <= reject;
         if (do_deck) deck <= deck + DECK_W'(1);
         if (do_push) begin
            case (add_cat)
               CAT_SMALL: small_total <= small_total + ONE_T;
               CAT_SEVEN: seven_total <= seven_total + ONE_T;
               CAT_LARGE: large_total <= large_total + ONE_T;
               default: ;
            endcase
            hist_mem[wr_ptr] <= add_cat;
            wr_ptr           <= wr_ptr + PTR_W'(1);
            // Full ring: the oldest entry is overwritten and silently lost.
            if (hist_cnt != HC_W'(HIST_DEPTH)) hist_cnt <= hist_cnt + HC_W'(1);
         end
         if (do_pop) begin
            case (pop_cat)
               CAT_SMALL: small_total <= small_total - ONE_T;
               CAT_SEVEN: seven_total <= seven_total - ONE_T;
               CAT_LARGE: large_total <= large_total - ONE_T;
               default: ;
            endcase
            wr_ptr   <= pop_ptr;
            hist_cnt <= hist_cnt - HC_W'(1);
         end
      end
   end

`ifdef SHOE_COUNTER_TRUE_COUNT_EN
   localparam int DIV_W  = TOTAL_W + 6;
   localparam int ITER_W = $clog2(DIV_W + 1);

   function automatic logic signed [TOTAL_W-1:0] apply_sign(input logic neg,
                                                             input logic [TOTAL_W-1:0] mag);
      return neg ? -$signed(mag) : $signed(mag);
   endfunction

   logic               accepted;
   logic               tc_pend, tc_busy, tc_neg;
   logic [ITER_W-1:0]  tc_iter;
   logic [DIV_W-1:0]   tc_quo, quo_nxt, dividend;
   logic [TOTAL_W:0]   tc_rem, rem_nxt, trial;
   logic [TOTAL_W-1:0] tc_div, off_mag;
   logic               q_bit;

   assign accepted = do_pop | do_deck | do_push;
   assign off_mag  = offset[TOTAL_W-1] ? $unsigned(-offset) : $unsigned(offset);
   assign dividend = DIV_W'(off_mag) * DIV_W'(52);
   assign trial    = {tc_rem[TOTAL_W-1:0], tc_quo[DIV_W-1]};
   assign q_bit    = trial >= {1'b0, tc_div};
   assign rem_nxt  = q_bit ? trial - {1'b0, tc_div} : trial;
   assign quo_nxt  = {tc_quo[DIV_W-2:0], q_bit};

   // Load one cycle after the accepted event so the divider sees settled totals.
   always_ff @(posedge clk) begin
      if (rst) begin
         true_count <= '0;
         tc_valid   <= 1'b1;
         tc_pend    <= 1'b0;
         tc_busy    <= 1'b0;
         tc_iter    <= '0;
      end else if (accepted) begin
         tc_pend  <= 1'b1;
         tc_busy  <= 1'b0;
         tc_valid <= 1'b0;
      end else if (tc_pend) begin
         tc_pend <= 1'b0;
         if (remaining == '0) begin
            true_count <= '0;
            tc_valid   <= 1'b1;
         end else begin
            tc_busy <= 1'b1;
            tc_iter <= ITER_W'(DIV_W);
            tc_quo  <= dividend;
            tc_rem  <= '0;
            tc_div  <= remaining;
            tc_neg  <= offset[TOTAL_W-1];
         end
      end else if (tc_busy) begin
         tc_quo  <= quo_nxt;
         tc_rem  <= rem_nxt;
         tc_iter <= tc_iter - ITER_W'(1);
         if (tc_iter == ITER_W'(1)) begin
            tc_busy    <= 1'b0;
            tc_valid   <= 1'b1;
            true_count <= apply_sign(tc_neg, quo_nxt[TOTAL_W-1:0]);
         end
      end
   end
`endif

endmodule

// File: tb/tb_shoe_counter.sv
// Scoreboard bench for shoe_counter: directed events push expected state, a monitor compares.
module tb_shoe_counter;

   localparam int TW = 16;
   localparam int HD = 16;

   logic clk = 1'b0;
   logic rst = 1'b0, small_add = 1'b0, seven_add = 1'b0, large_add = 1'b0;
   logic deck_add = 1'b0, back = 1'b0;
   logic [7:0]           deck;
   logic [TW-1:0]        small_total, seven_total, large_total, total, remaining;
   logic signed [TW-1:0] offset;
   logic [4:0]           hist_cnt;
   logic                 err;
`ifdef SHOE_COUNTER_TRUE_COUNT_EN
   logic signed [TW-1:0] true_count;
   logic                 tc_valid;
`endif

   shoe_counter dut (
      .clk(clk), .rst(rst), .small_add(small_add), .seven_add(seven_add),
      .large_add(large_add), .deck_add(deck_add), .back(back),
      .deck(deck), .small_total(small_total), .seven_total(seven_total),
      .large_total(large_total), .total(total), .remaining(remaining),
      .offset(offset), .hist_cnt(hist_cnt), .err(err)
`ifdef SHOE_COUNTER_TRUE_COUNT_EN
      , .true_count(true_count), .tc_valid(tc_valid)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int   dk, sm, sv, lg, off, hc;
      logic er;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic stim_vld = 1'b0;
   logic ev_seen  = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) ev_seen <= stim_vld;

   always @(negedge clk) begin
      if (ev_seen) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: DUT output with no expectation queued (t=%0t)", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("deck", longint'(deck), e.dk);
            chk("small_total", longint'(small_total), e.sm);
            chk("seven_total", longint'(seven_total), e.sv);
            chk("large_total", longint'(large_total), e.lg);
            chk("total", longint'(total), e.sm + e.sv + e.lg);
            chk("remaining", longint'(remaining), 52 * e.dk - (e.sm + e.sv + e.lg));
            chk("offset", longint'(offset), e.off);
            chk("hist_cnt", longint'(hist_cnt), e.hc);
            chk("err", longint'(err), longint'(e.er));
         end
      end
   end

   // One-cycle event: r b d s v l, then expected deck small seven large offset hist_cnt err
   task automatic ev(input logic r, b, d, s, v, l,
                     input int edk, esm, esv, elg, eoff, ehc, input logic eer);
      exp_t e;
      @(posedge clk); #1;
      rst = r; back = b; deck_add = d; small_add = s; seven_add = v; large_add = l;
      stim_vld = 1'b1;
      e.dk = edk; e.sm = esm; e.sv = esv; e.lg = elg; e.off = eoff; e.hc = ehc; e.er = eer;
      q.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      rst = 0; back = 0; deck_add = 0; small_add = 0; seven_add = 0; large_add = 0;
      stim_vld = 1'b0;
   endtask

`ifdef SHOE_COUNTER_TRUE_COUNT_EN
   task automatic wait_tc(input int exp_cycles, input int exp_tc);
      int n;
      n = 0;
      while (!tc_valid && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("tc_latency", n, exp_cycles);
      chk("tc_valid", longint'(tc_valid), 1);
      chk("true_count", longint'(true_count), exp_tc);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset, error on empty shoe, basic accounting and priority rules
      ev(1,0,0,0,0,0, 0,0,0,0,0,0,0);
      ev(0,0,0,1,0,0, 0,0,0,0,0,0,1);
      ev(0,1,0,0,0,0, 0,0,0,0,0,0,1);
      ev(0,0,1,0,0,0, 1,0,0,0,0,0,0);
      ev(0,0,1,0,0,0, 2,0,0,0,0,0,0);
      ev(0,0,0,1,0,0, 2,1,0,0,1,1,0);
      ev(0,0,0,1,0,0, 2,2,0,0,2,2,0);
      ev(0,0,0,1,0,0, 2,3,0,0,3,3,0);
      ev(0,0,0,0,0,1, 2,3,0,1,2,4,0);
      ev(0,0,1,0,0,0, 2,3,0,1,2,4,1);
      ev(0,0,0,1,0,1, 2,3,0,1,2,4,1);
      ev(0,1,1,0,0,0, 2,3,0,0,3,3,0);
      ev(0,1,0,1,0,0, 2,2,0,0,2,2,0);
      ev(0,0,0,0,1,0, 2,2,1,0,2,3,0);
      ev(0,1,0,0,0,0, 2,2,0,0,2,2,0);
      ev(0,1,0,0,0,0, 2,1,0,0,1,1,0);
      ev(0,1,0,0,0,0, 2,0,0,0,0,0,0);
      ev(0,1,0,0,0,0, 2,0,0,0,0,0,1);

      // Per-deck small-card limit, then mid-operation reset clears the ring
      ev(1,0,0,0,0,0, 0,0,0,0,0,0,0);
      ev(0,0,1,0,0,0, 1,0,0,0,0,0,0);
      for (int i = 1; i <= 20; i++) ev(0,0,0,1,0,0, 1,i,0,0,i,(i < HD) ? i : HD,0);
      ev(0,0,0,1,0,0, 1,20,0,0,20,HD,1);
      ev(1,0,0,0,0,0, 0,0,0,0,0,0,0);
      ev(0,1,0,0,0,0, 0,0,0,0,0,0,1);

      // History ring overflow: 18 sevens, only 16 undoable
      ev(0,0,1,0,0,0, 1,0,0,0,0,0,0);
      ev(0,0,1,0,0,0, 2,0,0,0,0,0,0);
      for (int i = 1; i <= 18; i++) ev(0,0,0,0,1,0, 2,0,i,0,0,(i < HD) ? i : HD,0);
      for (int k = 1; k <= 16; k++) ev(0,1,0,0,0,0, 2,0,18-k,0,0,HD-k,0);
      ev(0,1,0,0,0,0, 2,0,2,0,0,0,1);

      // Deck ceiling
      ev(1,0,0,0,0,0, 0,0,0,0,0,0,0);
      for (int i = 1; i <= 8; i++) ev(0,0,1,0,0,0, i,0,0,0,0,0,0);
      ev(0,0,1,0,0,0, 8,0,0,0,0,0,1);
      ev(0,0,0,0,0,1, 8,0,0,1,-1,1,0);
      idle();

`ifdef SHOE_COUNTER_TRUE_COUNT_EN
      ev(1,0,0,0,0,0, 0,0,0,0,0,0,0);
      idle();
      @(negedge clk);
      chk("tc_valid_reset", longint'(tc_valid), 1);
      chk("true_count_reset", longint'(true_count), 0);
      ev(0,0,1,0,0,0, 1,0,0,0,0,0,0);
      for (int i = 1; i <= 6; i++) ev(0,0,0,1,0,0, 1,i,0,0,i,i,0);
      idle();
      @(negedge clk);
      wait_tc(TW + 7, 6);
      ev(0,0,0,1,0,0, 1,7,0,0,7,7,0);
      repeat (5) idle();
      ev(0,0,0,0,0,1, 1,7,0,1,6,8,0);
      idle();
      @(negedge clk);
      chk("tc_valid_drop", longint'(tc_valid), 0);
      wait_tc(TW + 7, 6 * 52 / 44);
      ev(0,1,0,0,0,0, 1,7,0,0,7,7,0);
      ev(0,1,0,0,0,0, 1,6,0,0,6,6,0);
      ev(0,0,0,0,0,1, 1,6,0,1,5,7,0);
      idle();
      @(negedge clk);
      wait_tc(TW + 7, 5);
`endif

      begin
         int n;
         n = 0;
         while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
